// File: rtl/normalize_left.sv
// Multi-cycle left normalizer: shifts an 18-bit fraction left one bit per cycle
// until bit 17 is set, tracking exponent decrement and shift count.
module normalize_left (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] fraction_in,
  input  logic [7:0]  exp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] fraction_out,
  output logic [7:0]  exp_out,
  output logic [7:0]  shift_out,
  output logic        zero_out,
  output logic        denorm_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [17:0] frac_r;
  logic [7:0]  exp_r;
  logic [7:0]  cnt_r;

  // Gated by rst_n so no operand is taken while reset is asserted.
  assign in_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      frac_r       <= '0;
      exp_r        <= '0;
      cnt_r        <= '0;
      out_valid    <= 1'b0;
      fraction_out <= '0;
      exp_out      <= '0;
      shift_out    <= '0;
      zero_out     <= 1'b0;
      denorm_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            frac_r     <= fraction_in;
            exp_r      <= exp_in;
            cnt_r      <= '0;
            zero_out   <= 1'b0;
            denorm_out <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (frac_r == '0) begin
            zero_out     <= 1'b1;
            fraction_out <= '0;
            exp_out      <= '0;
            shift_out    <= cnt_r;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (frac_r[17]) begin
            fraction_out <= frac_r;
            exp_out      <= exp_r;
            shift_out    <= cnt_r;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (exp_r <= 8'd1) begin
            denorm_out   <= 1'b1;
            fraction_out <= frac_r;
            exp_out      <= '0;
            shift_out    <= cnt_r;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            frac_r <= {frac_r[16:0], 1'b0};
            exp_r  <= exp_r - 8'd1;
            cnt_r  <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
